// File: rtl/mantissa_normalizer.sv
// Pipelined mantissa normaliser: leading-one detect, left shift, exponent adjust.
// Ports: clk/rst (async, active-high); in_valid/in_ready + Sum_mag/exp_in in;
//        out_valid/out_ready + mant_out/exp_out/msb_pos/zero/denorm/underflow out.
module mantissa_normalizer #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8,
    parameter int STAGES    = 2,
    parameter int SUBNORMAL = 1,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     Sum_mag,
    input  logic [EXP_WIDTH-1:0] exp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     mant_out,
    output logic [EXP_WIDTH-1:0] exp_out,
    output logic [WIDTH_LOG-1:0] msb_pos,
    output logic                 zero,
    output logic                 denorm,
    output logic                 underflow
);

    localparam int CW = (EXP_WIDTH > WIDTH_LOG) ? EXP_WIDTH : WIDTH_LOG;
    localparam logic [WIDTH_LOG-1:0] TOP = WIDTH_LOG'(WIDTH - 1);

    // Leading-one search. Only bits that are a definite 1 update the
    // position, so unknown bits below the leading one cannot disturb it.
    logic [WIDTH_LOG-1:0] f_pos;
    logic [WIDTH_LOG-1:0] f_shift;
    logic                 f_zero;

    always_comb begin
        f_pos  = '0;
        f_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (Sum_mag[i] == 1'b1) begin
                f_pos  = WIDTH_LOG'(i);
                f_zero = 1'b0;
            end
        end
    end

    assign f_shift = f_zero ? '0 : TOP - f_pos;

    // Inputs of the shift/exponent stage, fed either by stage-1
    // registers or directly by the input port.
    logic                 b_valid;
    logic                 b_zero;
    logic [WIDTH-1:0]     b_mag;
    logic [EXP_WIDTH-1:0] b_exp;
    logic [WIDTH_LOG-1:0] b_pos;
    logic [WIDTH_LOG-1:0] b_shift;
    logic                 out_load;

    assign out_load = !out_valid || out_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic                 s1_valid;
            logic                 s1_zero;
            logic [WIDTH-1:0]     s1_mag;
            logic [EXP_WIDTH-1:0] s1_exp;
            logic [WIDTH_LOG-1:0] s1_pos;
            logic [WIDTH_LOG-1:0] s1_shift;
            logic                 s1_load;

            assign s1_load = !s1_valid || out_load;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_zero  <= 1'b0;
                    s1_mag   <= '0;
                    s1_exp   <= '0;
                    s1_pos   <= '0;
                    s1_shift <= '0;
                end else if (s1_load) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_zero  <= f_zero;
                        s1_mag   <= Sum_mag;
                        s1_exp   <= exp_in;
                        s1_pos   <= f_pos;
                        s1_shift <= f_shift;
                    end
                end
            end

            assign in_ready = s1_load;
            assign b_valid  = s1_valid;
            assign b_zero   = s1_zero;
            assign b_mag    = s1_mag;
            assign b_exp    = s1_exp;
            assign b_pos    = s1_pos;
            assign b_shift  = s1_shift;
        end else if (STAGES == 1) begin : g_one
            assign in_ready = out_load;
            assign b_valid  = in_valid;
            assign b_zero   = f_zero;
            assign b_mag    = Sum_mag;
            assign b_exp    = exp_in;
            assign b_pos    = f_pos;
            assign b_shift  = f_shift;
        end else begin : g_bad
            $error("mantissa_normalizer: STAGES must be 1 or 2");
        end
    endgenerate

    // Compare at the wider of the two widths so neither side wraps.
    logic [CW-1:0]        b_exp_w;
    logic [CW-1:0]        b_shift_w;
    logic                 b_under;
    logic [WIDTH-1:0]     n_mant;
    logic [EXP_WIDTH-1:0] n_exp;
    logic                 n_den;
    logic                 n_uf;

    assign b_exp_w   = CW'(b_exp);
    assign b_shift_w = CW'(b_shift);
    assign b_under   = b_exp_w < b_shift_w;

    always_comb begin
        n_mant = '0;
        n_exp  = '0;
        n_den  = 1'b0;
        n_uf   = 1'b0;
        if (!b_zero) begin
            if (!b_under) begin
                n_mant = b_mag << b_shift;
                n_exp  = EXP_WIDTH'(b_exp_w - b_shift_w);
            end else if (SUBNORMAL != 0) begin
                // Shift only as far as the exponent allows.
                n_mant = b_mag << b_exp;
                n_den  = 1'b1;
            end else begin
                n_uf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            mant_out  <= '0;
            exp_out   <= '0;
            msb_pos   <= '0;
            zero      <= 1'b0;
            denorm    <= 1'b0;
            underflow <= 1'b0;
        end else if (out_load) begin
            out_valid <= b_valid;
            if (b_valid) begin
                mant_out  <= n_mant;
                exp_out   <= n_exp;
                msb_pos   <= b_pos;
                zero      <= b_zero;
                denorm    <= n_den;
                underflow <= n_uf;
            end
        end
    end

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Bench for mantissa_normalizer: three instances (2-stage gradual underflow,
// 1-stage gradual underflow, 2-stage flush-to-zero) against a reference model.
module tb_mantissa_normalizer;

    localparam int N = 3;

    typedef struct packed {
        logic [7:0] mant;
        logic [7:0] e;
        logic [2:0] pos;
        logic       z;
        logic       dn;
        logic       uf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid  [N];
    logic       in_ready  [N];
    logic [7:0] sum_mag   [N];
    logic [7:0] exp_in    [N];
    logic       out_valid [N];
    logic       out_ready [N];
    logic [7:0] mant_o    [N];
    logic [7:0] exp_o     [N];
    logic [2:0] pos_o     [N];
    logic       z_o       [N];
    logic       dn_o      [N];
    logic       uf_o      [N];
    res_t       got       [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mantissa_normalizer #(
        .WIDTH(8), .EXP_WIDTH(8), .STAGES(2), .SUBNORMAL(1)
    ) u_two (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .Sum_mag(sum_mag[0]), .exp_in(exp_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .mant_out(mant_o[0]), .exp_out(exp_o[0]), .msb_pos(pos_o[0]),
        .zero(z_o[0]), .denorm(dn_o[0]), .underflow(uf_o[0])
    );

    mantissa_normalizer #(
        .WIDTH(8), .EXP_WIDTH(8), .STAGES(1), .SUBNORMAL(1)
    ) u_one (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .Sum_mag(sum_mag[1]), .exp_in(exp_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .mant_out(mant_o[1]), .exp_out(exp_o[1]), .msb_pos(pos_o[1]),
        .zero(z_o[1]), .denorm(dn_o[1]), .underflow(uf_o[1])
    );

    mantissa_normalizer #(
        .WIDTH(8), .EXP_WIDTH(8), .STAGES(2), .SUBNORMAL(0)
    ) u_ftz (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .Sum_mag(sum_mag[2]), .exp_in(exp_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .mant_out(mant_o[2]), .exp_out(exp_o[2]), .msb_pos(pos_o[2]),
        .zero(z_o[2]), .denorm(dn_o[2]), .underflow(uf_o[2])
    );

    always_comb begin
        for (int k = 0; k < N; k++)
            got[k] = {mant_o[k], exp_o[k], pos_o[k], z_o[k], dn_o[k], uf_o[k]};
    end

    function automatic int lat(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    function automatic bit sub(input int k);
        return k != 2;
    endfunction

    // Value-level model: leading one via log2, shift via multiplication.
    function automatic res_t model(input logic [7:0] m, input logic [7:0] e,
                                   input bit s);
        res_t r;
        int   p;
        int   sh;
        r = '0;
        if (m == 8'h00) begin
            r.z = 1'b1;
            return r;
        end
        p     = $clog2(int'(m) + 1) - 1;
        sh    = 7 - p;
        r.pos = 3'(p);
        if (int'(e) >= sh) begin
            r.mant = 8'(int'(m) * (2 ** sh));
            r.e    = 8'(int'(e) - sh);
        end else if (s) begin
            r.mant = 8'(int'(m) * (2 ** int'(e)));
            r.dn   = 1'b1;
        end else begin
            r.uf = 1'b1;
        end
        return r;
    endfunction

    task automatic drive_all(input logic v, input logic [7:0] m,
                             input logic [7:0] e);
        for (int k = 0; k < N; k++) begin
            in_valid[k] = v;
            sum_mag[k]  = m;
            exp_in[k]   = e;
        end
    endtask

    task automatic ready_all(input logic r);
        for (int k = 0; k < N; k++) out_ready[k] = r;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive_all(1'b0, 8'h00, 8'h00);
        ready_all(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_all(1'b0, 8'h00, 8'h00);
        ready_all(1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || got[k] !== '0) begin
                failures++;
                $display("FAIL reset_state dut=%0d valid=%b ready=%b out=%h required 0/1/0",
                         k, out_valid[k], in_ready[k], got[k]);
            end
        end
        rst = 1'b0;
        drive_all(1'b1, 8'h13, 8'd9);
        @(negedge clk);
        drive_all(1'b1, 8'h05, 8'd9);
        @(negedge clk);
        drive_all(1'b0, 8'h00, 8'h00);
        #1;
        checks++;
        if (out_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_inflight valid=%b required 1", out_valid[0]);
        end
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || got[k] !== '0) begin
                failures++;
                $display("FAIL reset_async dut=%0d valid=%b ready=%b out=%h required 0/1/0",
                         k, out_valid[k], in_ready[k], got[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                checks++;
                if (out_valid[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_stale dut=%0d valid=%b required 0", k, out_valid[k]);
                end
            end
        end
    endtask

    task automatic test_onehot_walk();
        res_t want;
        pulse_reset();
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            drive_all(1'b1, 8'(1 << p), 8'd20);
            for (int c = 1; c <= 2; c++) begin
                @(negedge clk);
                drive_all(1'b0, 8'h00, 8'h00);
                #1;
                for (int k = 0; k < N; k++) begin
                    want = model(8'(1 << p), 8'd20, sub(k));
                    checks++;
                    if (lat(k) == c) begin
                        if (out_valid[k] !== 1'b1 || got[k] !== want) begin
                            failures++;
                            $display("FAIL walk dut=%0d pos=%0d valid=%b got=%h want=%h",
                                     k, p, out_valid[k], got[k], want);
                        end
                    end else if (out_valid[k] !== 1'b0) begin
                        failures++;
                        $display("FAIL walk_latency dut=%0d pos=%0d cycle=%0d valid=%b required 0",
                                 k, p, c, out_valid[k]);
                    end
                end
                if (c == 2 && (p == 0 || p == 7)) begin
                    checks++;
                    if ({mant_o[0], exp_o[0], pos_o[0]} !==
                        {8'h80, (p == 0) ? 8'd13 : 8'd20, 3'(p)}) begin
                        failures++;
                        $display("FAIL walk_anchor pos=%0d mant=%h exp=%0d msb=%0d",
                                 p, mant_o[0], exp_o[0], pos_o[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_zero_x();
        pulse_reset();
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            if (t == 0) drive_all(1'b1, 8'h00, 8'($urandom));
            else drive_all(1'b1, 8'b0001_xxxx, 8'd10);
            for (int c = 1; c <= 2; c++) begin
                @(negedge clk);
                drive_all(1'b0, 8'h00, 8'h00);
                #1;
                for (int k = 0; k < N; k++) begin
                    if (lat(k) != c) continue;
                    checks++;
                    if (t == 0) begin
                        if (out_valid[k] !== 1'b1 || got[k] !== {19'd0, 3'b100}) begin
                            failures++;
                            $display("FAIL zero_in dut=%0d valid=%b got=%h want=%h",
                                     k, out_valid[k], got[k], {19'd0, 3'b100});
                        end
                    end else if (out_valid[k] !== 1'b1 ||
                                 {exp_o[k], pos_o[k], z_o[k], dn_o[k], uf_o[k]} !==
                                 {8'd7, 3'd4, 3'b000} ||
                                 (mant_o[k] ==? 8'b1xxx_x000) !== 1'b1) begin
                        failures++;
                        $display("FAIL x_tolerant dut=%0d got=%h want exp=7 msb=4 flags=0 mant=1xxxx000",
                                 k, got[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_underflow();
        logic [7:0] cm [3];
        logic [7:0] ce [3];
        res_t       ws [3];
        res_t       wf [3];
        res_t       want;
        cm[0] = 8'h04; ce[0] = 8'd3;
        ws[0] = {8'h20, 8'h00, 3'd2, 3'b010};
        wf[0] = {8'h00, 8'h00, 3'd2, 3'b001};
        cm[1] = 8'h04; ce[1] = 8'd5;
        ws[1] = {8'h80, 8'h00, 3'd2, 3'b000};
        wf[1] = {8'h80, 8'h00, 3'd2, 3'b000};
        cm[2] = 8'h01; ce[2] = 8'd0;
        ws[2] = {8'h01, 8'h00, 3'd0, 3'b010};
        wf[2] = {8'h00, 8'h00, 3'd0, 3'b001};
        pulse_reset();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            drive_all(1'b1, cm[t], ce[t]);
            for (int c = 1; c <= 2; c++) begin
                @(negedge clk);
                drive_all(1'b0, 8'h00, 8'h00);
                #1;
                for (int k = 0; k < N; k++) begin
                    if (lat(k) != c) continue;
                    want = sub(k) ? ws[t] : wf[t];
                    checks++;
                    if (out_valid[k] !== 1'b1 || got[k] !== want) begin
                        failures++;
                        $display("FAIL underflow dut=%0d case=%0d got=%h want=%h",
                                 k, t, got[k], want);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bm [6];
        logic [7:0] be [6];
        res_t prev;
        bit   stalled  = 1'b0;
        bit   saw_full = 1'b0;
        bit   acc;
        bit   take;
        bit   want_rdy;
        int   sent = 0;
        int   rcv  = 0;
        int   occ  = 0;
        int   cyc  = 0;
        prev = '0;
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            bm[i] = 8'($urandom_range(1, 255));
            be[i] = 8'($urandom);
        end
        while (rcv < 6 && cyc < 40) begin
            @(negedge clk);
            out_ready[0] = !(cyc >= 3 && cyc < 6);
            in_valid[0]  = sent < 6;
            if (sent < 6) begin
                sum_mag[0] = bm[sent];
                exp_in[0]  = be[sent];
            end
            #1;
            want_rdy = (occ < 2) || out_ready[0];
            checks++;
            if (in_ready[0] !== want_rdy) begin
                failures++;
                $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", cyc, in_ready[0], want_rdy);
            end
            if (in_ready[0] === 1'b0) saw_full = 1'b1;
            if (stalled) begin
                checks++;
                if (out_valid[0] !== 1'b1 || got[0] !== prev) begin
                    failures++;
                    $display("FAIL bp_hold cycle=%0d got=%h held=%h", cyc, got[0], prev);
                end
            end
            take = out_valid[0] && out_ready[0];
            if (take) begin
                checks++;
                if (rcv >= 6) begin
                    failures++;
                    $display("FAIL bp_extra cycle=%0d got=%h want none", cyc, got[0]);
                end else if (got[0] !== model(bm[rcv], be[rcv], 1'b1)) begin
                    failures++;
                    $display("FAIL bp_order beat=%0d got=%h want=%h",
                             rcv, got[0], model(bm[rcv], be[rcv], 1'b1));
                end
                rcv++;
            end
            acc = in_valid[0] && in_ready[0];
            if (acc) sent++;
            occ     = occ + int'(acc) - int'(take);
            prev    = got[0];
            stalled = out_valid[0] && !out_ready[0];
            cyc++;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        checks++;
        if (rcv != 6 || !saw_full) begin
            failures++;
            $display("FAIL bp_delivery beats=%0d full_seen=%b want 6/1", rcv, saw_full);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_duplicate valid=%b required 0", out_valid[0]);
        end
    endtask

    task automatic test_exhaustive();
        res_t       sb      [N][256];
        res_t       prev    [N];
        bit         stalled [N];
        int         idx     [N];
        int         rd      [N];
        int         occ     [N];
        logic [7:0] ev      [256];
        bit         acc;
        bit         take;
        bit         want_rdy;
        bit         done = 1'b0;
        int         cyc  = 0;
        pulse_reset();
        for (int v = 0; v < 256; v++)
            ev[v] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 8)) : 8'($urandom);
        for (int k = 0; k < N; k++) begin
            idx[k] = 0;
            rd[k] = 0;
            occ[k] = 0;
            stalled[k] = 1'b0;
            prev[k] = '0;
        end
        while (!done && cyc < 4000) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                out_ready[k] = $urandom_range(0, 3) != 0;
                in_valid[k]  = idx[k] < 256 && $urandom_range(0, 7) != 0;
                if (idx[k] < 256) begin
                    sum_mag[k] = 8'(idx[k]);
                    exp_in[k]  = ev[idx[k]];
                end
            end
            #1;
            done = 1'b1;
            for (int k = 0; k < N; k++) begin
                want_rdy = (occ[k] < lat(k)) || out_ready[k];
                checks++;
                if (in_ready[k] !== want_rdy) begin
                    failures++;
                    $display("FAIL ex_in_ready dut=%0d cycle=%0d got=%b want=%b",
                             k, cyc, in_ready[k], want_rdy);
                end
                if (stalled[k]) begin
                    checks++;
                    if (out_valid[k] !== 1'b1 || got[k] !== prev[k]) begin
                        failures++;
                        $display("FAIL ex_hold dut=%0d cycle=%0d got=%h held=%h",
                                 k, cyc, got[k], prev[k]);
                    end
                end
                take = out_valid[k] && out_ready[k];
                if (take) begin
                    checks++;
                    if (rd[k] >= idx[k]) begin
                        failures++;
                        $display("FAIL ex_spurious dut=%0d cycle=%0d got=%h", k, cyc, got[k]);
                    end else if (got[k] !== sb[k][rd[k]]) begin
                        failures++;
                        $display("FAIL ex_data dut=%0d beat=%0d got=%h want=%h",
                                 k, rd[k], got[k], sb[k][rd[k]]);
                    end
                    rd[k]++;
                end
                acc = in_valid[k] && in_ready[k];
                if (acc) begin
                    sb[k][idx[k]] = model(8'(idx[k]), ev[idx[k]], sub(k));
                    idx[k]++;
                end
                occ[k]     = occ[k] + int'(acc) - int'(take);
                prev[k]    = got[k];
                stalled[k] = out_valid[k] && !out_ready[k];
                if (rd[k] < 256) done = 1'b0;
            end
            cyc++;
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (rd[k] != 256) begin
                failures++;
                $display("FAIL ex_count dut=%0d delivered=%0d want 256", k, rd[k]);
            end
        end
    endtask

    initial begin
        drive_all(1'b0, 8'h00, 8'h00);
        ready_all(1'b1);
        test_reset();
        test_onehot_walk();
        test_zero_x();
        test_underflow();
        test_backpressure();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
